// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the instruction/data memory port arbiter.
// Holds the FSM state enum, access-size codes, jon bit indices and the alignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    F_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam int JON_DEC = 0;
  localparam int JON_EX  = 1;
  localparam int JON_WB  = 2;

  // Size code 3 is never legal, so it is treated the same as a misaligned address.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; it holds at all-ones instead
// of wrapping back to zero.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {CW{1'b1}}))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates the single shared memory port between fetch and the data stage.
// Data accesses take priority over fetches, and only one transaction is outstanding at a time.
//
// state  | meaning
// IDLE   | no transaction outstanding; arbitrate between data and fetch requests
// F_BUSY | fetch request issued to memory; waiting for mem_ack
// D_BUSY | data load/store issued to memory; waiting for mem_ack
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    jon,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_f,
  output logic          stall_m,
  output logic          proto_err,
  output logic [CW-1:0] stall_cnt
);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    mem_size_q, mem_size_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          d_err_q, d_err_d;
  logic          proto_err_q, proto_err_d;

  // Decode and writeback flags are carried for the detector interface but not used here.
  logic unused_jon;
  assign unused_jon = jon[JON_DEC] ^ jon[JON_WB];

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    d_err_d     = 1'b0;
    proto_err_d = proto_err_q | (d_req & ~jon[JON_EX]) | (mem_ack & (state_q == IDLE));

    case (state_q)
      IDLE: begin
        // A requester still holds req during its valid cycle; ignore it there so it is not reissued.
        if (d_req && !d_valid_q) begin
          if (misaligned(d_size, d_addr[1:0])) begin
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
          end else begin
            state_d     = D_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we;
            mem_size_d  = d_size;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end
        end else if (if_req && !if_valid_q && !jon[JON_EX]) begin
          state_d     = F_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_size_d  = SZ_W;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end
      end
      F_BUSY: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_valid_d = 1'b1;
          if_rdata_d = mem_rdata;
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign stall_m = d_req  && !((state_q == D_BUSY) && mem_ack);
  assign stall_f = if_req && !((state_q == F_BUSY) && mem_ack);

  sat_counter #(.CW(CW)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_f),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Testbench for mem_port_arb: directed scenarios followed by random single
// transactions, all checked against a transaction-level reference model.
module tb_mem_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [2:0]    jon;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall_f;
  logic          stall_m;
  logic          proto_err;
  logic [CW-1:0] stall_cnt;

  mem_port_arb #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .jon(jon),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m), .proto_err(proto_err), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic f_ack = 1'b0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic [DW-1:0] exp_if_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fetch is stalled in every cycle it is requested except the cycle its own ack arrives.
  task automatic tick();
    if (if_req && !f_ack && exp_cnt < CNT_MAX) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jon = 3'b000; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'd0; d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0; f_ack = 1'b0;
  endtask

  task automatic model_reset();
    exp_cnt = 0; exp_d_rdata = '0; exp_if_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_rdata"}, if_rdata, 0);   chk({tag, "_if_valid"}, if_valid, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);     chk({tag, "_d_valid"}, d_valid, 0);
    chk({tag, "_d_err"}, d_err, 0);         chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);       chk({tag, "_mem_size"}, mem_size, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);   chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_proto_err"}, proto_err, 0); chk({tag, "_stall_cnt"}, stall_cnt, 0);
  endtask

  task automatic do_data(input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rdata);
    logic bad;
    bad = (size == 2'd3) || ((addr % (32'd1 << size)) != 0);
    jon = 3'b010; d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    #1 chk("stall_m_req", stall_m, 1);
    tick();
    if (bad) begin
      chk("err_d_valid", d_valid, 1);
      chk("err_d_err", d_err, 1);
      chk("err_no_mem_req", mem_req, 0);
      d_req = 1'b0;
      tick();
      chk("err_d_valid_off", d_valid, 0);
      chk("err_mem_req_off", mem_req, 0);
    end else begin
      chk("d_mem_req", mem_req, 1);
      chk("d_mem_we", mem_we, we);
      chk("d_mem_size", mem_size, size);
      chk("d_mem_addr", mem_addr, addr);
      chk("d_mem_wdata", mem_wdata, wdata);
      for (int i = 0; i < lat; i++) begin
        #1 chk("stall_m_wait", stall_m, 1);
        tick();
        chk("d_mem_req_hold", mem_req, 1);
        chk("d_mem_addr_hold", mem_addr, addr);
      end
      mem_ack = 1'b1; mem_rdata = rdata;
      #1 chk("stall_m_ack", stall_m, 0);
      tick();
      mem_ack = 1'b0; d_req = 1'b0;
      if (!we) exp_d_rdata = rdata;
      chk("d_valid_pulse", d_valid, 1);
      chk("d_err_clean", d_err, 0);
      chk("d_rdata", d_rdata, exp_d_rdata);
      chk("d_mem_req_drop", mem_req, 0);
      tick();
      chk("d_valid_off", d_valid, 0);
    end
    jon = 3'b000;
    chk("d_stall_cnt", stall_cnt, exp_cnt);
    chk("d_proto_err", proto_err, 0);
  endtask

  task automatic do_fetch(input logic [AW-1:0] addr, input int lat, input logic [DW-1:0] rdata);
    jon = 3'b000; if_req = 1'b1; if_addr = addr;
    #1 chk("stall_f_req", stall_f, 1);
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_we", mem_we, 0);
    chk("f_mem_size", mem_size, 2);
    chk("f_mem_addr", mem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("f_mem_req_hold", mem_req, 1);
    end
    mem_ack = 1'b1; f_ack = 1'b1; mem_rdata = rdata;
    #1 chk("stall_f_ack", stall_f, 0);
    tick();
    mem_ack = 1'b0; f_ack = 1'b0; if_req = 1'b0;
    exp_if_rdata = rdata;
    chk("if_valid_pulse", if_valid, 1);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("f_mem_req_drop", mem_req, 0);
    tick();
    chk("if_valid_off", if_valid, 0);
    chk("f_stall_cnt", stall_cnt, exp_cnt);
    chk("f_proto_err", proto_err, 0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [1:0] sz;
    int kind;

    idle_inputs();
    rst_n = 1'b0;
    #1 chk_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    chk_all_zero("post_reset");

    // Fetch blocked by a memory op in execute.
    jon = 3'b010; if_req = 1'b1; if_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("blk_no_mem_req", mem_req, 0);
    end
    chk("blk_stall_cnt", stall_cnt, exp_cnt);
    chk("blk_stall_cnt_4", stall_cnt, 4);
    chk("blk_proto_err", proto_err, 0);
    if_req = 1'b0; jon = 3'b000;

    do_data(1'b0, 2'd2, 32'h100, 32'h0, 2, 32'hDEADBEEF);
    do_data(1'b0, 2'd1, 32'h101, 32'h0, 0, 32'h0);

    // Simultaneous data and fetch: data first, fetch issues two cycles after the data ack.
    jon = 3'b010; if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h300;
    #1 chk("both_stall_f", stall_f, 1);
    tick();
    chk("both_data_first", mem_addr, 32'h300);
    chk("both_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1 chk("both_stall_f_dack", stall_f, 1);
    chk("both_stall_m_dack", stall_m, 0);
    tick();
    mem_ack = 1'b0; d_req = 1'b0; jon = 3'b000;
    exp_d_rdata = 32'h1234_5678;
    chk("both_d_valid", d_valid, 1);
    chk("both_d_rdata", d_rdata, exp_d_rdata);
    chk("both_gap_mem_req", mem_req, 0);
    #1 chk("both_stall_f_gap", stall_f, 1);
    tick();
    chk("both_f_mem_req", mem_req, 1);
    chk("both_f_addr", mem_addr, 32'h200);
    mem_ack = 1'b1; f_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; f_ack = 1'b0; if_req = 1'b0;
    exp_if_rdata = 32'hCAFE_F00D;
    chk("both_if_valid", if_valid, 1);
    chk("both_if_rdata", if_rdata, exp_if_rdata);
    tick();
    chk("both_stall_cnt", stall_cnt, exp_cnt);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      if (kind == 0) begin
        do_fetch(a, $urandom_range(0, 3), $urandom);
      end else begin
        sz = 2'($urandom_range(0, 3));
        do_data(kind == 2, sz, a, $urandom, $urandom_range(0, 3), $urandom);
      end
    end

    // Drive the stall counter past its ceiling.
    jon = 3'b010; if_req = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_cnt", stall_cnt, exp_cnt);
    chk("sat_stall_cnt_max", stall_cnt, CNT_MAX);
    if_req = 1'b0; jon = 3'b000;

    // Reset in the middle of a data access.
    jon = 3'b010; d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h500;
    tick();
    chk("rst_mid_mem_req", mem_req, 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    idle_inputs();
    tick();
    chk("rst_mid_no_valid", d_valid, 0);
    rst_n = 1'b1;
    model_reset();
    tick();
    do_fetch(32'h600, 1, 32'hA5A5_5A5A);

    // Ack while idle is a protocol violation and sticks until reset.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("proto_ack_idle", proto_err, 1);
    tick(); tick();
    chk("proto_sticky", proto_err, 1);
    rst_n = 1'b0;
    #1 chk("proto_cleared", proto_err, 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();

    // Data request without a memory op in execute.
    jon = 3'b000; d_req = 1'b1; d_size = 2'd3; d_addr = 32'h0;
    tick();
    d_req = 1'b0;
    chk("proto_dreq_no_jon", proto_err, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Arbiter for the single shared memory port between instruction fetch and the data-memory stage of the 5-stage pipeline. It sits directly downstream of the load/store opcode detector and consumes its 3-bit `jon` flags (decode/execute/writeback hold a memory op). It grants the port to data accesses ahead of fetches, runs a req/ack handshake to memory, and returns read data and stall signals to the pipeline.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `CW`, default 16: stall-counter width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `jon` in 3: memory-op flags; bit0 decode, bit1 execute, bit2 writeback.
- `if_req` in 1: fetch request, held until `if_valid`.
- `if_addr` in AW: fetch address.
- `if_rdata` out DW: fetched word, registered.
- `if_valid` out 1: one-cycle pulse, fetch complete.
- `d_req` in 1: data request, held until `d_valid`.
- `d_we` in 1: 1 = store.
- `d_size` in 2: 0 byte, 1 half, 2 word; 3 is illegal.
- `d_addr` in AW: data address.
- `d_wdata` in DW: store data.
- `d_rdata` out DW: load data, registered.
- `d_valid` out 1: one-cycle pulse, data access done.
- `d_err` out 1: qualifies `d_valid`; misaligned access or illegal size.
- `mem_req` out 1: memory request, registered.
- `mem_we`, `mem_size`, `mem_addr`, `mem_wdata` out: request payload, registered.
- `mem_ack` in 1: memory done; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DW: memory read data.
- `stall_f` out 1: freeze PC and fetch.
- `stall_m` out 1: freeze execute and earlier stages.
- `proto_err` out 1: sticky protocol violation flag.
- `stall_cnt` out CW: saturating count of `stall_f` cycles.

## Operation
- FSM states: `IDLE`, `F_BUSY`, `D_BUSY`. Only one memory transaction is outstanding at a time.
- Transitions out of `IDLE`:
  - `d_req` with an aligned address → `D_BUSY`.
  - `d_req` misaligned (half on an odd address, word with `addr[1:0]≠0`, or `d_size=3`) → no issue; next cycle `d_valid=1` and `d_err=1`; stay `IDLE`.
  - Else `if_req && !jon[1]` → `F_BUSY`. A memory op in execute blocks new fetch starts.
  - Else stay `IDLE`.
- `F_BUSY` / `D_BUSY`:
  - `mem_req=1` with the payload captured on entry; payload is stable until ack.
  - On `mem_ack`: capture `mem_rdata` into `if_rdata` or `d_rdata` (load only; a store leaves `d_rdata` unchanged). Pulse `if_valid` or `d_valid` next cycle. Return to `IDLE`.
- Stall outputs (combinational from state and inputs):
  - `stall_m = d_req && !(state==D_BUSY && mem_ack)`.
  - `stall_f = if_req && !(state==F_BUSY && mem_ack)`.
- `proto_err` is set when `d_req` is high while `jon[1]` is low, or when `mem_ack` arrives in `IDLE`. It clears only on reset.
- `stall_cnt` increments every cycle `stall_f=1` and saturates at `2^CW-1`.

## Timing
- Reset values: state `IDLE`; all outputs 0, including rdata registers and `stall_cnt`. Reset asserted mid-transaction drops `mem_req` immediately; the memory must tolerate abandonment.
- Minimum latency:
  - Request seen in `IDLE` at cycle 0 → `mem_req` high at cycle 1.
  - Ack at cycle 1 → `valid` pulse and data at cycle 2, with state back in `IDLE`.
- Maximum throughput: one access per 2 cycles.
- Simultaneous `d_req` and `if_req` in `IDLE`: data wins; fetch waits at least until the data access completes.
- `if_req` dropping while `F_BUSY`: the transaction still completes and `if_valid` still pulses.
- Misaligned data request: `d_valid`/`d_err` at cycle 1; no `mem_req`.

## Structure
- Shared package `mem_arb_pkg`: state enum, `d_size` encodings (`SZ_B`, `SZ_H`, `SZ_W`), `jon` bit indices.
- One sub-module `sat_counter` (parameter CW, inputs `inc`/`clr`) for `stall_cnt`.

## Test plan
- Word load `d_addr=0x100`, `jon=3'b010`, ack after 3 cycles, `mem_rdata=0xDEADBEEF` → `mem_req` high 3 cycles, `d_rdata=0xDEADBEEF`, `d_valid` 1 cycle, `stall_m` low in the ack cycle.
- `if_req` and `d_req` asserted together → data issued first. Fetch `mem_req` rises 2 cycles after the data ack; `stall_f` stays high throughout.
- `if_req` with `jon[1]=1` and no `d_req` for 4 cycles → no fetch issue; `stall_cnt=4`; `proto_err` stays 0.
- Half load at `d_addr=0x101` → `d_valid=1` and `d_err=1` at cycle 1; `mem_req` never asserts.
- `rst_n` pulsed low mid-`D_BUSY` → `mem_req=0` immediately, no `d_valid`, all outputs 0; a new fetch succeeds after release.
- `mem_ack` while `IDLE` → `proto_err=1`, held until reset.
